uart_frame_receiver: RTL and testbench
======================================

# uart_frame_receiver

Serial receive counterpart to the board's 8N1 UART transmitter. It deserialises asynchronous `RxD` traffic into bytes and assembles `BYTES` consecutive bytes into one word, first byte received in the most-significant position. A 24-bit word such as 0x414243 ("ABC") sent by the transmitter is reproduced intact on `data`. It sits between the board RX pin and the morse-translation datapath.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD`, 9600: line rate. `CLKS_PER_BIT` = `CLK_FREQ`/`BAUD` (integer division, must be ≥ 4).
- `BYTES`, 3: bytes per word. Word width `W` = 8·`BYTES`.
- `TIMEOUT_BITS`, 20: inter-byte idle limit, in bit times, before a partial word is discarded.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `RxD`  in  1  serial line; idles high; asynchronous to `clk`.
- `data`  out  W  last complete word; holds its value until the next complete word.
- `data_valid`  out  1  one-cycle pulse when `data` updates.
- `frame_error`  out  1  one-cycle pulse on a bad stop bit.
- `busy`  out  1  high while any state other than IDLE is active, or while a partial word is held.

## Operation
- `RxD` passes through a 2-flop synchronizer (reset value 1). All references below to the line mean the synchronized value `rx_s`.
- Byte FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when `rx_s` is 0, clear the bit counter and go to START.
  - START: wait `CLKS_PER_BIT`/2 cycles, then resample. If the line is 0, go to DATA. If it is 1, treat it as a glitch and return to IDLE with no output.
  - DATA: sample every `CLKS_PER_BIT` cycles, at mid-bit. Take 8 bits, LSB first, then go to STOP.
  - STOP: sample at mid-bit.
    - Line is 1: the byte is good. Shift it into the word assembler and go to IDLE.
    - Line is 0: pulse `frame_error`, discard the partial word and the byte, and go to BREAK.
  - BREAK: wait until the line is 1, then go to IDLE. This prevents a held-low line from being decoded as 0x00 bytes.
- Word assembler:
  - A byte counter runs 0..`BYTES`-1. Each good byte is shifted in: `shreg <= {shreg[W-9:0], byte}`.
  - On the `BYTES`-th good byte, load `data` with the completed word, pulse `data_valid`, and clear the counter.
- Inter-byte timeout:
  - Applies while the byte counter is non-zero and the FSM is in IDLE.
  - A counter measures the idle time. When it reaches `TIMEOUT_BITS`·`CLKS_PER_BIT` cycles, clear the byte counter silently (no pulse).
  - The timeout counter restarts on every transition into IDLE.
- Reset values: `data`=0, `data_valid`=0, `frame_error`=0, `busy`=0, FSM=IDLE, all counters 0, synchronizer flops 1.
- Reset asserted mid-byte or mid-word aborts everything immediately. No pulse is emitted during or after the reset.

## Timing
- Synchronizer latency is 2 cycles from the `RxD` edge to `rx_s`.
- The start-bit check occurs `CLKS_PER_BIT`/2 cycles after `rx_s` falls. Data bit *k* is sampled `CLKS_PER_BIT`·(k+1) cycles after the start check; the stop bit is sampled at 9·`CLKS_PER_BIT`.
- `data_valid` and the new `data` value are registered and appear 1 cycle after the stop sample of the last byte.
- `frame_error` appears 1 cycle after the failing stop sample.
- `data_valid` and `frame_error` are never high in the same cycle.
- Back-to-back frames are supported: a start bit that begins immediately after the stop-bit sample is detected from IDLE without loss, with no idle gap required.
- There is no back-pressure. The consumer must capture `data` before the next word completes; `data` is simply overwritten.

## Structure
- Shared package `uart_pkg`:
  - byte-FSM state enum (IDLE/START/DATA/STOP/BREAK);
  - `clks_per_bit()` constant function;
  - 8N1 frame constants (8 data bits, 1 stop bit).
  The transmitter should use the same package.
- Sub-module `uart_rx_byte` contains the synchronizer, the byte FSM and the bit/baud counters. Outputs: `byte_out`, `byte_valid`, `stop_err`, `idle`.
- The top level `uart_frame_receiver` contains the word assembler and the inter-byte timeout.

## Test plan
Bench parameters: `CLK_FREQ`=160, `BAUD`=10 (16 clocks/bit), `BYTES`=3, `TIMEOUT_BITS`=20.
- Send 0x41, 0x42, 0x43 back-to-back → one `data_valid` pulse, `data`=0x414243, `frame_error` never high.
- Send 0x53, 0x4F, 0x53 with 5-bit-time gaps, then 0xFF, 0x00, 0x80 → two pulses, with `data`=0x534F53 then 0xFF0080.
- Send byte 0x41 with the stop bit forced to 0, then 0x41, 0x42, 0x43 → `frame_error` pulses once, and one `data_valid` pulse with `data`=0x414243.
- Send 0x41, idle 25 bit times, then 0x42, 0x43, 0x44 → no pulse after the first byte, and `data`=0x424344.
- Apply a 4-cycle low glitch on `RxD` while idle → no byte accepted, no pulses, `busy` returns to 0.
- Assert `rst_n`=0 mid-way through the second byte, release, then send 0x41, 0x42, 0x43 → all outputs read 0 during reset, then exactly one pulse with `data`=0x414243.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions used by both the transmitter and the receiver.
// Contents: byte-FSM state encoding, frame constants, baud divisor helper.
// No logic of its own; imported with import uart_pkg::*.
package uart_pkg;

    // Receiver byte-FSM states.
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_e;

    // 8N1 framing.
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Clock cycles per bit time (integer division; callers need a result >= 4).
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_frame_receiver_if.sv
// Line-side/consumer bundle of the UART word receiver.
// Ports: RxD (serial in), data/data_valid (word out), frame_error, busy.
// master = the side driving RxD and consuming words; slave = the receiver.
interface uart_frame_receiver_if #(
    parameter int W = 24
);
    logic         RxD;
    logic [W-1:0] data;
    logic         data_valid;
    logic         frame_error;
    logic         busy;

    modport master (
        output RxD,
        input  data,
        input  data_valid,
        input  frame_error,
        input  busy
    );

    modport slave (
        input  RxD,
        output data,
        output data_valid,
        output frame_error,
        output busy
    );
endinterface

// File: rtl/uart_rx_byte.sv
// Purpose: synchronise RxD and deserialise one 8N1 byte; byte_valid/stop_err are combinational pulses in the stop-sample cycle.
// Latency: 2-cycle synchronizer, stop bit sampled 9.5 bit times after the synchronized start edge.
// Backpressure: none; the consumer must take byte_out in the byte_valid cycle.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CPB = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       stop_err,
    output logic       idle
);

    localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE  = 3'(RX_IDLE);
    localparam logic [2:0] S_START = 3'(RX_START);
    localparam logic [2:0] S_DATA  = 3'(RX_DATA);
    localparam logic [2:0] S_STOP  = 3'(RX_STOP);
    localparam logic [2:0] S_BREAK = 3'(RX_BREAK);

    logic          rx_meta_q, rx_s_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;

    // Two-flop synchronizer; resets to the idle (mark) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                // Half a bit in: still low means a real start bit; high is a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};   // LSB arrives first
                    if (bit_q == LAST_BIT) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        byte_valid = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        stop_err = 1'b1;
                        state_d  = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                // Hold off until the line returns to mark so a stuck-low line is not read as 0x00s.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign byte_out = shift_q;
    assign idle     = (state_q == S_IDLE);

endmodule

// File: rtl/uart_frame_receiver.sv
// Purpose: 8N1 receiver assembling BYTES bytes into a word (first byte MSB), with inter-byte timeout.
// Latency: data/data_valid and frame_error registered, 1 cycle after the stop-bit sample.
// Backpressure: none; data is overwritten by the next completed word.
module uart_frame_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 9600,
    parameter int BYTES        = 3,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_frame_receiver_if.slave rx_if
);

    localparam int CPB      = clks_per_bit(CLK_FREQ, BAUD);
    localparam int W        = DATA_BITS * BYTES;
    localparam int TO_LIMIT = TIMEOUT_BITS * CPB;
    localparam int TW       = (TO_LIMIT > 1) ? $clog2(TO_LIMIT) : 1;
    localparam int BCW      = $clog2(BYTES + 1);
    localparam logic [TW-1:0]  TO_M1    = TW'(TO_LIMIT - 1);
    localparam logic [BCW-1:0] LAST_IDX = BCW'(BYTES - 1);

    logic [7:0]     byte_out;
    logic           byte_valid, stop_err, idle;

    logic [W-1:0]   shreg_q, shreg_d;
    logic [W-1:0]   data_q, data_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic           data_valid_q, data_valid_d;
    logic           frame_error_q, frame_error_d;
    logic [W-1:0]   word_next;

    uart_rx_byte #(.CPB(CPB)) u_rx_byte (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_i       (rx_if.RxD),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .stop_err   (stop_err),
        .idle       (idle)
    );

    // Drop the oldest byte off the top; new byte enters at the bottom.
    assign word_next = W'({shreg_q, byte_out});

    always_comb begin
        shreg_d       = shreg_q;
        data_d        = data_q;
        byte_cnt_d    = byte_cnt_q;
        to_cnt_d      = to_cnt_q;
        data_valid_d  = 1'b0;
        frame_error_d = 1'b0;

        // Idle timer: held at zero outside IDLE so every return to IDLE restarts it.
        if (!idle) begin
            to_cnt_d = '0;
        end else if (byte_cnt_q != '0) begin
            if (to_cnt_q == TO_M1) begin
                byte_cnt_d = '0;
                to_cnt_d   = '0;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end

        // byte_valid/stop_err only fire outside IDLE, so they never race the timeout.
        if (byte_valid) begin
            if (byte_cnt_q == LAST_IDX) begin
                data_d       = word_next;
                data_valid_d = 1'b1;
                byte_cnt_d   = '0;
            end else begin
                shreg_d    = word_next;
                byte_cnt_d = byte_cnt_q + BCW'(1);
            end
        end else if (stop_err) begin
            frame_error_d = 1'b1;
            byte_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q       <= '0;
            data_q        <= '0;
            byte_cnt_q    <= '0;
            to_cnt_q      <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            shreg_q       <= shreg_d;
            data_q        <= data_d;
            byte_cnt_q    <= byte_cnt_d;
            to_cnt_q      <= to_cnt_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign rx_if.data        = data_q;
    assign rx_if.data_valid  = data_valid_q;
    assign rx_if.frame_error = frame_error_q;
    assign rx_if.busy        = !idle || (byte_cnt_q != '0);

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Bench for uart_frame_receiver at 16 clocks/bit, 3 bytes/word, 20-bit-time timeout.
// Frames are described as (byte, good stop, gap in bit times before the frame);
// a queue-based model turns that list into the expected words and error count.
module tb_uart_frame_receiver;
    localparam int CLK_FREQ = 160, BAUD = 10, BYTES = 3, TIMEOUT_BITS = 20;
    localparam int CPB = CLK_FREQ / BAUD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_frame_receiver_if #(.W(24)) bus ();

    uart_frame_receiver #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .BYTES(BYTES), .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_if (bus)
    );

    int checks = 0;
    int errors = 0;

    // Observations.
    logic [23:0] got_words[$];
    int fe_seen = 0;
    int overlap = 0;

    always @(negedge clk) begin
        if (bus.data_valid) got_words.push_back(bus.data);
        if (bus.frame_error) fe_seen++;
        if (bus.data_valid && bus.frame_error) overlap++;
    end

    // Stimulus description and model expectations.
    logic [7:0]  frm_byte[$];
    bit          frm_good[$];
    int          frm_gap[$];
    logic [23:0] exp_words[$];
    int          exp_fe;

    task automatic clear_scenario();
        frm_byte.delete(); frm_good.delete(); frm_gap.delete();
        got_words.delete(); fe_seen = 0; overlap = 0;
    endtask

    task automatic add_frame(input logic [7:0] b, input bit good, input int gap);
        frm_byte.push_back(b); frm_good.push_back(good); frm_gap.push_back(gap);
    endtask

    // Word-level reference: a long idle or a bad frame discards the partial word.
    task automatic run_model();
        logic [7:0]  partial[$];
        logic [23:0] w;
        exp_words.delete();
        exp_fe = 0;
        foreach (frm_byte[i]) begin
            if (frm_gap[i] > TIMEOUT_BITS) partial.delete();
            if (!frm_good[i]) begin
                exp_fe++;
                partial.delete();
            end else begin
                partial.push_back(frm_byte[i]);
                if (partial.size() == BYTES) begin
                    w = '0;
                    foreach (partial[j]) w = (w << 8) | 24'(partial[j]);
                    exp_words.push_back(w);
                    partial.delete();
                end
            end
        end
    endtask

    task automatic drive_bits(input logic v, input int n);
        bus.RxD = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit good, input int gap);
        drive_bits(1'b1, gap * CPB);
        drive_bits(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bits(b[i], CPB);
        drive_bits(good ? 1'b1 : 1'b0, CPB);
        if (!good) drive_bits(1'b1, CPB);
    endtask

    task automatic send_all();
        foreach (frm_byte[i]) send_frame(frm_byte[i], frm_good[i], frm_gap[i]);
        drive_bits(1'b1, 25 * CPB);
    endtask

    task automatic test_reset();
        bus.RxD = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.data !== 24'h0) begin errors++; $display("FAIL reset_data: got %h expected 000000", bus.data); end
        checks++; if ({bus.data_valid, bus.frame_error, bus.busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {bus.data_valid, bus.frame_error, bus.busy}); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if ({bus.data_valid, bus.frame_error, bus.busy} !== 3'b000 || bus.data !== 24'h0) begin errors++; $display("FAIL post_reset: got %b/%h expected 000/000000", {bus.data_valid, bus.frame_error, bus.busy}, bus.data); end
    endtask

    task automatic test_back_to_back();
        clear_scenario();
        add_frame(8'h41, 1, 1); add_frame(8'h42, 1, 0); add_frame(8'h43, 1, 0);
        run_model();
        send_all();
        checks++; if (got_words.size() != exp_words.size()) begin errors++; $display("FAIL b2b_pulses: got %0d expected %0d", got_words.size(), exp_words.size()); end
        else foreach (exp_words[i]) begin checks++; if (got_words[i] !== exp_words[i]) begin errors++; $display("FAIL b2b_word%0d: got %h expected %h", i, got_words[i], exp_words[i]); end end
        checks++; if (fe_seen != exp_fe) begin errors++; $display("FAIL b2b_fe: got %0d expected %0d", fe_seen, exp_fe); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_gaps();
        clear_scenario();
        add_frame(8'h53, 1, 5); add_frame(8'h4F, 1, 5); add_frame(8'h53, 1, 5);
        add_frame(8'hFF, 1, 1); add_frame(8'h00, 1, 0); add_frame(8'h80, 1, 0);
        run_model();
        send_all();
        checks++; if (got_words.size() != exp_words.size()) begin errors++; $display("FAIL gaps_pulses: got %0d expected %0d", got_words.size(), exp_words.size()); end
        else foreach (exp_words[i]) begin checks++; if (got_words[i] !== exp_words[i]) begin errors++; $display("FAIL gaps_word%0d: got %h expected %h", i, got_words[i], exp_words[i]); end end
        checks++; if (bus.data !== 24'hFF0080) begin errors++; $display("FAIL gaps_hold: got %h expected ff0080", bus.data); end
        checks++; if (fe_seen != exp_fe || overlap != 0) begin errors++; $display("FAIL gaps_fe: got %0d/%0d expected %0d/0", fe_seen, overlap, exp_fe); end
    endtask

    task automatic test_frame_error();
        clear_scenario();
        add_frame(8'h41, 0, 1);
        add_frame(8'h41, 1, 1); add_frame(8'h42, 1, 0); add_frame(8'h43, 1, 0);
        run_model();
        send_all();
        checks++; if (fe_seen != exp_fe) begin errors++; $display("FAIL ferr_count: got %0d expected %0d", fe_seen, exp_fe); end
        checks++; if (got_words.size() != exp_words.size()) begin errors++; $display("FAIL ferr_pulses: got %0d expected %0d", got_words.size(), exp_words.size()); end
        else foreach (exp_words[i]) begin checks++; if (got_words[i] !== exp_words[i]) begin errors++; $display("FAIL ferr_word%0d: got %h expected %h", i, got_words[i], exp_words[i]); end end
        checks++; if (overlap != 0) begin errors++; $display("FAIL ferr_overlap: got %0d expected 0", overlap); end
    endtask

    task automatic test_timeout();
        clear_scenario();
        add_frame(8'h41, 1, 1);
        add_frame(8'h42, 1, 25); add_frame(8'h43, 1, 0); add_frame(8'h44, 1, 0);
        run_model();
        send_all();
        checks++; if (got_words.size() != exp_words.size()) begin errors++; $display("FAIL tmo_pulses: got %0d expected %0d", got_words.size(), exp_words.size()); end
        else foreach (exp_words[i]) begin checks++; if (got_words[i] !== exp_words[i]) begin errors++; $display("FAIL tmo_word%0d: got %h expected %h", i, got_words[i], exp_words[i]); end end
        checks++; if (fe_seen != exp_fe) begin errors++; $display("FAIL tmo_fe: got %0d expected %0d", fe_seen, exp_fe); end
    endtask

    task automatic test_glitch();
        clear_scenario();
        drive_bits(1'b0, 4);
        drive_bits(1'b1, 3 * CPB);
        checks++; if (got_words.size() != 0 || fe_seen != 0) begin errors++; $display("FAIL glitch_pulses: got %0d/%0d expected 0/0", got_words.size(), fe_seen); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b expected 0", bus.busy); end
        // A glitch mistaken for a byte would shift this word.
        add_frame(8'h11, 1, 0); add_frame(8'h22, 1, 0); add_frame(8'h33, 1, 0);
        run_model();
        send_all();
        checks++; if (got_words.size() != exp_words.size()) begin errors++; $display("FAIL glitch_after_pulses: got %0d expected %0d", got_words.size(), exp_words.size()); end
        else foreach (exp_words[i]) begin checks++; if (got_words[i] !== exp_words[i]) begin errors++; $display("FAIL glitch_word%0d: got %h expected %h", i, got_words[i], exp_words[i]); end end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        clear_scenario();
        send_frame(8'h41, 1, 1);
        b = 8'h42;
        drive_bits(1'b1, CPB);
        drive_bits(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bits(b[i], CPB);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (bus.data !== 24'h0 || {bus.data_valid, bus.frame_error, bus.busy} !== 3'b000) begin errors++; $display("FAIL rstmid_outputs: got %h/%b expected 000000/000", bus.data, {bus.data_valid, bus.frame_error, bus.busy}); end
        bus.RxD = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checks++; if (got_words.size() != 0 || fe_seen != 0) begin errors++; $display("FAIL rstmid_nopulse: got %0d/%0d expected 0/0", got_words.size(), fe_seen); end
        add_frame(8'h41, 1, 2); add_frame(8'h42, 1, 0); add_frame(8'h43, 1, 0);
        run_model();
        send_all();
        checks++; if (got_words.size() != exp_words.size()) begin errors++; $display("FAIL rstmid_pulses: got %0d expected %0d", got_words.size(), exp_words.size()); end
        else foreach (exp_words[i]) begin checks++; if (got_words[i] !== exp_words[i]) begin errors++; $display("FAIL rstmid_word%0d: got %h expected %h", i, got_words[i], exp_words[i]); end end
        checks++; if (fe_seen != 0) begin errors++; $display("FAIL rstmid_fe: got %0d expected 0", fe_seen); end
    endtask

    // Gaps avoid the neighbourhood of the timeout so the outcome is unambiguous.
    task automatic test_random();
        clear_scenario();
        for (int i = 0; i < 14; i++) begin
            add_frame(8'($urandom_range(0, 255)),
                      $urandom_range(0, 7) != 0,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(25, 30))
                                                  : int'($urandom_range((i == 0) ? 1 : 0, 8)));
        end
        run_model();
        send_all();
        checks++; if (got_words.size() != exp_words.size()) begin errors++; $display("FAIL rand_pulses: got %0d expected %0d", got_words.size(), exp_words.size()); end
        else foreach (exp_words[i]) begin checks++; if (got_words[i] !== exp_words[i]) begin errors++; $display("FAIL rand_word%0d: got %h expected %h", i, got_words[i], exp_words[i]); end end
        checks++; if (fe_seen != exp_fe) begin errors++; $display("FAIL rand_fe: got %0d expected %0d", fe_seen, exp_fe); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL rand_overlap: got %0d expected 0", overlap); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rand_busy: got %b expected 0", bus.busy); end
    endtask

    initial begin
        bus.RxD = 1'b1;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_frame_error();
        test_timeout();
        test_glitch();
        test_reset_mid();
        for (int r = 0; r < 3; r++) test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
